// File: rtl/input_debouncer_pkg.sv
// Shared constants for the input debouncer slice.
package input_debouncer_pkg;

  // 10 ms stable time at a 100 MHz system clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // Short stable time used for simulation builds.
  localparam int unsigned DEBOUNCE_CYCLES_SIM = 8;

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// Single-bit debouncer: polarity correction, two-flop synchronizer,
// stable-time qualification counter and registered edge pulses.
module debounce_bit
  import input_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Per-bit qualification states; the state is implied by sync2 vs stable.
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] QUALIFY = 1'b1;

  logic             in_pol;
  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] count;
  logic [0:0]       state;

  assign in_pol = ACTIVE_LOW ? ~in_raw : in_raw;
  assign state  = (sync2 != stable) ? QUALIFY : IDLE;
  assign level  = stable;

  // Two-flop synchronizer for the asynchronous board pin.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in_pol;
      sync2 <= sync1;
    end
  end

  // Qualify a changed input for DEBOUNCE_CYCLES edges before accepting it.
  // The pulses are loaded on the same edge as stable, so they line up with
  // the first cycle in which level shows the new value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable <= 1'b0;
      count  <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (state == QUALIFY) begin
        if (count == CNT_MAX) begin
          stable <= sync2;
          count  <= '0;
          rise   <= sync2;
          fall   <= ~sync2;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Multi-bit input debouncer for board keys and switches, with a sticky
// per-bit edge capture register.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_raw,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] edge_capture
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .in_raw (in_raw[i]),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // Sticky rise flags; a rise arriving with its clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clear) | rise;
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed + randomized bench for input_debouncer against a sample-history model.
module tb_input_debouncer;
  import input_debouncer_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned N = DEBOUNCE_CYCLES_SIM;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_raw;
  logic [W-1:0] edge_clear;
  logic [W-1:0] level;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] edge_capture;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Model: history of polarity-corrected samples, newest at the back.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_level = '0;
  logic [W-1:0] m_rise  = '0;
  logic [W-1:0] m_fall  = '0;
  logic [W-1:0] m_ec    = '0;

  input_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_raw      (in_raw),
    .edge_clear  (edge_clear),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .edge_capture(edge_capture)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [W-1:0] got, input logic [W-1:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d got=%h exp=%h", tag, cycle, got, exp);
    end
  endtask

  // A bit flips when the N synchronized samples seen by this edge (taken two
  // and more edges ago) all disagree with the current level.
  task automatic model_edge();
    logic [W-1:0] nl, nr, nf, s;
    bit all_diff;
    if (!reset_n) begin
      hist = {};
      for (int j = 0; j < N + 1; j++) hist.push_back('0);
      m_level = '0; m_rise = '0; m_fall = '0; m_ec = '0;
    end else begin
      nl = m_level; nr = '0; nf = '0;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < N; j++) begin
          s = hist[j];
          if (s[b] == m_level[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          nl[b] = ~m_level[b];
          if (nl[b]) nr[b] = 1'b1; else nf[b] = 1'b1;
        end
      end
      m_ec    = (m_ec & ~edge_clear) | m_rise;
      m_level = nl; m_rise = nr; m_fall = nf;
      hist.push_back(~in_raw);
      void'(hist.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cycle++;
    #1;
    chk(level, m_level, "level");
    chk(rise, m_rise, "rise");
    chk(fall, m_fall, "fall");
    chk(edge_capture, m_ec, "edge_capture");
  endtask

  // Input changed before the next edge; count steps until rise[b] is seen.
  task automatic wait_rise(input int b, input int exp_n, input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (rise[b] === 1'b1) seen = 1'b1;
    end
    checks++;
    assert (seen && n == exp_n) else begin
      failures++;
      $error("FAIL %s latency got=%0d exp=%0d", tag, seen ? n : -1, exp_n);
    end
  endtask

  initial begin
    int pulses;
    int n;
    reset_n    = 1'b0;
    in_raw     = '1;
    edge_clear = '0;
    step();
    step();
    chk(level | rise | fall | edge_capture, '0, "reset_state");
    reset_n = 1'b1;
    repeat (5) step();

    // Clean press on bit 0 and the clear race.
    in_raw[0] = 1'b0;
    wait_rise(0, N + 2, "clean_press");
    chk(level, 4'b0001, "clean_level");
    edge_clear[0] = 1'b1;
    step();
    edge_clear[0] = 1'b0;
    chk(edge_capture, 4'b0001, "clear_race_set_wins");
    repeat (3) step();
    edge_clear[0] = 1'b1;
    step();
    edge_clear[0] = 1'b0;
    chk(edge_capture, 4'b0000, "clear_later");
    in_raw[0] = 1'b1;
    repeat (N + 4) step();

    // Bounce on bit 1: 3-cycle runs never qualify.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      in_raw[1] = ~in_raw[1];
      repeat (3) begin
        step();
        if (rise[1] === 1'b1) pulses++;
      end
    end
    chk(W'(pulses), '0, "bounce_no_rise");
    in_raw[1] = 1'b0;
    wait_rise(1, N + 2, "bounce_final");

    // Glitch on bit 2: N-1 low samples must not qualify.
    in_raw[2] = 1'b0;
    repeat (N - 1) step();
    in_raw[2] = 1'b1;
    pulses = 0;
    repeat (15) begin
      step();
      if (rise[2] === 1'b1 || fall[2] === 1'b1) pulses++;
    end
    chk(W'(pulses), '0, "glitch_no_pulse");
    chk({3'b000, level[2]}, '0, "glitch_level");

    // Reset in the middle of qualifying bit 3.
    in_raw[3] = 1'b0;
    repeat (7) step();
    reset_n = 1'b0;
    step();
    chk(level | rise | fall | edge_capture, '0, "reset_midqual");
    reset_n = 1'b1;
    wait_rise(3, N + 2, "reset_rerise");
    in_raw = '1;
    repeat (N + 4) step();

    // All bits at once.
    in_raw = '0;
    wait_rise(0, N + 2, "simul_press");
    chk(rise, 4'hF, "simul_rise");
    chk(level, 4'hF, "simul_level");
    step();
    chk(rise, 4'h0, "simul_rise_one_cycle");
    in_raw = '1;
    n = 0;
    while (fall === 4'h0 && n < 40) begin
      step();
      n++;
    end
    chk(fall, 4'hF, "simul_fall");
    chk(W'(n), W'(N + 2), "simul_fall_latency");
    step();
    chk(fall, 4'h0, "simul_fall_one_cycle");

    // Randomized traffic with occasional clears and resets.
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 9) == 0) in_raw[b] = ~in_raw[b];
      edge_clear = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : '0;
      reset_n    = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset_n    = 1'b1;
    edge_clear = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input bits (4 for KEY, 10 for SW).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: stable-time in clk cycles (10 ms at 100 MHz system_clock); legal range 2..2^24.
REQ-003 Parameter ACTIVE_LOW, default 1: when 1, raw inputs are inverted at the input so that outputs are active-high (pressed = 1).
REQ-004 clk  input  1  system clock (same domain as sys_clk_ref_clk of Computer_System).
REQ-005 reset_n  input  1  reset: one clock, synchronous, active-low.
REQ-006 in_raw  input  WIDTH  asynchronous board pins (KEY or SW).
REQ-007 edge_clear  input  WIDTH  per-bit clear mask for edge_capture, sampled each clk.
REQ-008 level  output  WIDTH  debounced, polarity-corrected level; drives pushbuttons_export / slider_switches_export.
REQ-009 rise  output  WIDTH  one-cycle pulse per bit on a debounced 0->1 transition.
REQ-010 fall  output  WIDTH  one-cycle pulse per bit on a debounced 1->0 transition.
REQ-011 edge_capture  output  WIDTH  sticky per-bit flag, set by rise and cleared by edge_clear.

Function
REQ-012 Each bit SHALL pass through a two-flop synchronizer (sync1, sync2) after optional inversion; no logic between the flops.
REQ-013 Each bit SHALL hold a stable register and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-014 Per-bit states SHALL be IDLE (sync2 == stable, counter = 0) and QUALIFY (sync2 != stable, counter counting).
REQ-015 In QUALIFY, the counter SHALL increment by 1 per cycle while sync2 != stable.
REQ-016 If sync2 returns equal to stable before the count completes, the counter SHALL clear to 0 on that edge and the bit SHALL return to IDLE without changing stable.
REQ-017 When counter == DEBOUNCE_CYCLES-1 and sync2 != stable, the next edge SHALL load stable <= sync2, clear the counter and return to IDLE.
REQ-018 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 Latency: a clean raw change first sampled at edge k SHALL appear on level after edge k+DEBOUNCE_CYCLES+1, i.e. visible in cycle k+DEBOUNCE_CYCLES+2.
REQ-020 level SHALL equal stable directly (registered output, no combinational path from in_raw).
REQ-021 rise/fall SHALL be registered, asserted for exactly the one cycle in which level first shows the new value.
REQ-022 edge_capture[i] SHALL set on rise[i]; edge_clear[i] clears it; simultaneous rise[i] and edge_clear[i] SHALL leave it set (set wins).
REQ-023 Bits SHALL be fully independent; simultaneous transitions on several bits SHALL each produce their own pulses in the same cycle.

Reset
REQ-024 With reset_n low at a clk edge: sync1, sync2, stable, counters, rise, fall, edge_capture SHALL all become 0; level SHALL read 0.
REQ-025 Reset mid-QUALIFY SHALL abort qualification; no rise/fall pulse SHALL be produced for the aborted transition.
REQ-026 A pressed input held through reset release SHALL be debounced afresh and SHALL produce a rise after REQ-019 latency.

Structure
REQ-027 Shared package SHALL hold the DEBOUNCE_CYCLES default (1000000) and the simulation value (8); no typedefs needed.
REQ-028 One sub-module debounce_bit (synchronizer, counter, stable, edge pulses) SHALL be instantiated WIDTH times by a generate loop; edge_capture stays in the top.
REQ-029 Instantiation: KEY instance with WIDTH=4, ACTIVE_LOW=1; SW instance with WIDTH=10, ACTIVE_LOW=0; both replace the inline ~KEY inversion.

Verification (DEBOUNCE_CYCLES=8, WIDTH=4, ACTIVE_LOW=1)
REQ-030 Clean press: in_raw[0] 1->0 at edge 10, held -> level[0]=1 and rise[0]=1 in cycle 20 only; edge_capture[0]=1 from cycle 21.
REQ-031 Bounce: in_raw[1] toggles every 3 cycles for 30 cycles then holds 0 -> no rise during bounce; exactly one rise[1], 10 cycles after the final transition.
REQ-032 Glitch: in_raw[2] low for 7 cycles then high -> level[2] stays 0, no pulses, counter back to 0.
REQ-033 Clear race: edge_clear[0]=1 asserted in same cycle as rise[0] -> edge_capture[0] remains 1; clearing in a later cycle -> 0 next cycle.
REQ-034 Reset mid-QUALIFY: reset_n low for 1 cycle at counter=5 with input held pressed -> all outputs 0, then rise exactly 10 cycles after reset release.
REQ-035 Simultaneous: in_raw=4'b0000 from 4'b1111 at one edge -> level=4'hF and rise=4'hF in the same single cycle; release -> fall=4'hF once.
